// File: rtl/mem_seq.sv
// mem_seq: burst memory-access sequencer for a single-port SRAM.
// Latches base/length/direction on a request, then issues one chip-select
// strobe per en tick in WAIT, walking the address with wrap-around.
module mem_seq #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic          wr_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   len_i,
  input  logic          en_i,
  input  logic          abort_i,
  output logic [4:0]    st_o,
  output logic [AW-1:0] addr_o,
  output logic          csn_o,
  output logic          we_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    SETUP  = 5'b00010,
    WAIT   = 5'b00100,
    ACCESS = 5'b01000,
    DONE   = 5'b10000
  } state_e;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;

  // State register; reset returns to IDLE immediately, even mid-strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context and address/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      wr_q   <= wr_d;
      base_q <= base_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  // Next-state and datapath updates; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          wr_d    = wr_i;
          base_d  = base_i;
          len_d   = len_i;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        addr_d  = base_q;
        state_d = (len_q == '0) ? DONE : WAIT;
      end
      WAIT: begin
        if (en_i) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // len_q is nonzero here, so len_q-1 cannot underflow.
        if (cnt_q == len_q - {{AW{1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + {{AW{1'b0}}, 1'b1};
          addr_d  = addr_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Moore output decode straight from the state register.
  always_comb begin
    st_o   = state_q;
    addr_o = addr_q;
    csn_o  = (state_q != ACCESS);
    we_o   = (state_q == ACCESS) && wr_q;
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
  end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: directed cycle vectors plus hand-written burst sequences.
module tb_mem_seq;

  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          req, wr, en, abort;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic [4:0]    st_o;
  logic [AW-1:0] addr_o;
  logic          csn_o, we_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone = 0;
  logic [AW-1:0] sa[$];
  logic          sw[$];
  int            sc[$];
  logic [4:0]    stlog[$];

  mem_seq #(.AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .wr_i   (wr),
    .base_i (base),
    .len_i  (len),
    .en_i   (en),
    .abort_i(abort),
    .st_o   (st_o),
    .addr_o (addr_o),
    .csn_o  (csn_o),
    .we_o   (we_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       wr;
    logic [4:0] base;
    logic [5:0] len;
    logic       en;
    logic       abort;
    logic [4:0] st;
    logic [4:0] addr;
    logic       csn;
    logic       we;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vec[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, log strobes/done/state.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (csn_o == 1'b0) begin
      sa.push_back(addr_o);
      sw.push_back(we_o);
      sc.push_back(cyc);
    end
    if (done_o) ndone++;
    stlog.push_back(st_o);
  endtask

  task automatic clear_log();
    sa.delete();
    sw.delete();
    sc.delete();
    stlog.delete();
    ndone = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", busy_o, 0);
  endtask

  initial begin
    // Write burst base=5 len=3, en gapped, stray en in ACCESS and base change ignored.
    vec[0]  = '{1, 1, 5, 3, 0, 0, 5'd2,  5, 1, 0, 1, 0};
    vec[1]  = '{0, 0, 9, 7, 0, 0, 5'd4,  5, 1, 0, 1, 0};
    vec[2]  = '{1, 0, 9, 7, 0, 0, 5'd4,  5, 1, 0, 1, 0};
    vec[3]  = '{0, 0, 9, 7, 1, 0, 5'd8,  5, 0, 1, 1, 0};
    vec[4]  = '{0, 0, 9, 7, 1, 0, 5'd4,  6, 1, 0, 1, 0};
    vec[5]  = '{0, 0, 9, 7, 0, 0, 5'd4,  6, 1, 0, 1, 0};
    vec[6]  = '{0, 0, 9, 7, 1, 0, 5'd8,  6, 0, 1, 1, 0};
    vec[7]  = '{0, 0, 9, 7, 0, 0, 5'd4,  7, 1, 0, 1, 0};
    vec[8]  = '{0, 0, 9, 7, 1, 0, 5'd8,  7, 0, 1, 1, 0};
    vec[9]  = '{0, 0, 9, 7, 0, 0, 5'd16, 7, 1, 0, 1, 1};
    vec[10] = '{0, 0, 9, 7, 0, 0, 5'd1,  7, 1, 0, 0, 0};
    vec[11] = '{0, 0, 9, 7, 1, 0, 5'd1,  7, 1, 0, 0, 0};
    // vec[0]: addr still holds its reset value until SETUP loads base.
    vec[0].addr = 0;

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = 1'($urandom); wr = 1'($urandom); en = 1'($urandom); abort = 1'($urandom);
      base = 5'($urandom); len = 6'($urandom);
      step();
      check("rst_st", st_o, 1);
      check("rst_csn", csn_o, 1);
      check("rst_we", we_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
    end
    req = 0; wr = 0; en = 0; abort = 0; base = 0; len = 0;
    rst_n = 1'b1;
    step();
    check("post_rst_st", st_o, 1);

    // Table-driven write burst.
    clear_log();
    for (int i = 0; i < 12; i++) begin
      req = vec[i].req; wr = vec[i].wr; base = vec[i].base; len = vec[i].len;
      en = vec[i].en; abort = vec[i].abort;
      step();
      check($sformatf("v%0d_st", i), st_o, vec[i].st);
      check($sformatf("v%0d_addr", i), addr_o, vec[i].addr);
      check($sformatf("v%0d_csn", i), csn_o, vec[i].csn);
      check($sformatf("v%0d_we", i), we_o, vec[i].we);
      check($sformatf("v%0d_busy", i), busy_o, vec[i].busy);
      check($sformatf("v%0d_done", i), done_o, vec[i].done);
    end
    check("wr_ndone", ndone, 1);
    check("wr_nstrobe", sa.size(), 3);
    en = 0;

    // Read burst with wrap, en held high.
    clear_log();
    req = 1; wr = 0; base = 30; len = 4; en = 1;
    step();
    req = 0;
    wait_idle(40);
    check("rd_nstrobe", sa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] ea;
      ea = 5'(30 + i);
      check($sformatf("rd_addr%0d", i), sa[i], ea);
      check($sformatf("rd_we%0d", i), sw[i], 0);
      if (i > 0) check($sformatf("rd_gap%0d", i), sc[i] - sc[i-1], 2);
    end
    check("rd_ndone", ndone, 1);

    // Zero-length burst.
    clear_log();
    en = 1; req = 1; base = 7; len = 0;
    step();
    req = 0;
    check("z_setup", st_o, 2);
    step();
    check("z_done_st", st_o, 16);
    check("z_done", done_o, 1);
    step();
    check("z_idle", st_o, 1);
    check("z_busy", busy_o, 0);
    check("z_nstrobe", sa.size(), 0);

    // Full-length burst touching every address.
    clear_log();
    req = 1; wr = 1; base = 0; len = 32; en = 1;
    step();
    req = 0;
    wait_idle(100);
    check("full_nstrobe", sa.size(), 32);
    for (int i = 0; i < 32; i++) begin
      logic [4:0] ea;
      ea = 5'(i);
      check($sformatf("full_addr%0d", i), sa[i], ea);
    end
    check("full_ndone", ndone, 1);

    // Abort in WAIT after the 2nd strobe of an 8-word burst.
    clear_log();
    req = 1; wr = 1; base = 3; len = 8; en = 1;
    step();
    req = 0;
    for (int i = 0; i < 30 && sa.size() < 2; i++) step();
    check("ab_two", sa.size(), 2);
    step();
    check("ab_wait", st_o, 4);
    abort = 1;
    step();
    abort = 0;
    check("ab_idle", st_o, 1);
    check("ab_busy", busy_o, 0);
    repeat (5) step();
    check("ab_nstrobe", sa.size(), 2);
    check("ab_ndone", ndone, 0);
    req = 1; wr = 0; base = 20; len = 1;
    step();
    req = 0;
    wait_idle(20);
    check("ab_new_nstrobe", sa.size(), 3);
    check("ab_new_addr", sa[2], 20);
    check("ab_new_ndone", ndone, 1);

    // Back-to-back bursts with req held; base change applies to second burst only.
    clear_log();
    req = 1; wr = 1; base = 10; len = 2; en = 1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 1) base = 25;
      if (i == 8) req = 0;
    end
    begin
      logic [4:0] es[14];
      es = '{2, 4, 8, 4, 8, 16, 1, 2, 4, 8, 4, 8, 16, 1};
      for (int i = 0; i < 14; i++) check($sformatf("b2b_st%0d", i), stlog[i], es[i]);
    end
    check("b2b_nstrobe", sa.size(), 4);
    check("b2b_a0", sa[0], 10);
    check("b2b_a1", sa[1], 11);
    check("b2b_a2", sa[2], 25);
    check("b2b_a3", sa[3], 26);
    check("b2b_ndone", ndone, 2);

    // Asynchronous reset in the middle of an ACCESS cycle.
    clear_log();
    req = 1; wr = 1; base = 0; len = 2; en = 0;
    step();
    req = 0;
    step();
    en = 1;
    step();
    check("ar_access_csn", csn_o, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_csn", csn_o, 1);
    check("ar_st", st_o, 1);
    check("ar_we", we_o, 0);
    check("ar_busy", busy_o, 0);
    check("ar_addr", addr_o, 0);
    step();
    rst_n = 1'b1;
    en = 0;
    step();
    check("ar_after_st", st_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
